lsu_mem: RTL and testbench
==========================

LSU_MEM -- requirements
Module: lsu_mem

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath width (the bus is fixed at 64 bits).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  upstream (execute) presents an op.
REQ-005 SHALL have port in_ready  output  1  block can accept an op.
REQ-006 SHALL have port is_load / is_store  input  1 each  op class; both 0 means non-memory op.
REQ-007 SHALL have port mem_size  input  2  access size: 0=byte, 1=half, 2=word, 3=dword.
REQ-008 SHALL have port mem_unsigned  input  1  zero-extend the load when 1, sign-extend when 0.
REQ-009 SHALL have port addr  input  XLEN  byte address.
REQ-010 SHALL have port wdata  input  XLEN  store data, right-aligned.
REQ-011 SHALL have port exc_data_in  input  XLEN  execute-stage result, passed through.
REQ-012 SHALL have ports out_valid (output 1) and out_ready (input 1): handshake to the writeback stage.
REQ-013 SHALL have ports exc_data_out and mem_data_out, each output XLEN; and isloadEnable output 1, meaning the load result is valid for writeback.
REQ-014 SHALL have port misalign_err  output  1  access not naturally aligned.
REQ-015 SHALL have bus request ports: bus_req_valid (out 1), bus_req_ready (in 1), bus_req_addr (out 64, 8-byte aligned), bus_req_write (out 1), bus_req_wdata (out 64), bus_req_wstrb (out 8).
REQ-016 SHALL have bus response ports: bus_rsp_valid (in 1) and bus_rsp_rdata (in 64).

Function
REQ-017 SHALL implement the FSM states IDLE, REQ, WAIT, DONE.
REQ-018 SHALL drive in_ready=1 only in IDLE; an op is accepted when in_valid and in_ready are both 1, and all op fields are registered on acceptance.
REQ-019 On acceptance of a non-memory op, SHALL go to DONE; out_valid is asserted the next cycle (latency 1), with isloadEnable=0 and mem_data_out=0.
REQ-020 On acceptance of a memory op, SHALL check alignment: the address is misaligned when addr mod 2^mem_size is non-zero.
REQ-021 On a misaligned op, SHALL go directly to DONE with misalign_err=1, isloadEnable=0 and mem_data_out=0, and SHALL issue no bus request.
REQ-022 On an aligned memory op, SHALL go to REQ.
REQ-023 In REQ, SHALL hold bus_req_valid=1 with all request fields stable until bus_req_ready=1, then go to WAIT.
REQ-024 SHALL drive bus_req_addr = {addr[63:3], 3'b000}.
REQ-025 SHALL drive bus_req_wstrb = ((1 << 2^mem_size) - 1) << addr[2:0] for stores, and 0 for loads.
REQ-026 SHALL drive bus_req_wdata = wdata << (8*addr[2:0]).
REQ-027 In WAIT, SHALL capture bus_rsp_valid and go to DONE; bus_rsp_valid SHALL be ignored in every other state.
REQ-028 For loads, SHALL set mem_data_out = extend(bus_rsp_rdata >> (8*addr[2:0]), mem_size, mem_unsigned) and isloadEnable=1.
REQ-029 For stores, SHALL set mem_data_out=0 and isloadEnable=0; the response acts only as a write acknowledge.
REQ-030 In DONE, SHALL hold out_valid=1 with all outputs stable until out_ready=1, then go to IDLE.
REQ-031 SHALL not pipeline: at most one op is in flight, and in_ready=0 from acceptance until the DONE handshake completes.
REQ-032 SHALL take bus_rsp_valid arriving in the same cycle as bus_req_ready as the response only on a later cycle, i.e. only after entering WAIT.
REQ-033 SHALL pass exc_data_out through unchanged from the captured exc_data_in for every op.

Reset
REQ-034 While rst_n=0, SHALL hold state=IDLE and force out_valid, bus_req_valid, misalign_err and isloadEnable to 0, and all data outputs to 0, immediately and without waiting for clk.
REQ-035 A reset asserted mid-transaction (REQ or WAIT) SHALL abandon the op; a later stray bus_rsp_valid in IDLE SHALL be ignored.
REQ-036 After rst_n deasserts, in_ready SHALL be 1 at the first clock edge.

Verification
REQ-037 Load byte, signed: addr=0x1003, size=0, rdata=0x00000000_80000000 -> wstrb=0, bus_req_addr=0x1000, mem_data_out=0xFFFF_FFFF_FFFF_FF80, isloadEnable=1.
REQ-038 Load word, unsigned: addr=0x2004, rdata=0xDEADBEEF_00000000 -> mem_data_out=0x0000_0000_DEAD_BEEF.
REQ-039 Store half: addr=0x3006, wdata=0x1234 -> wstrb=0xC0, bus_req_wdata=0x1234_0000_0000_0000, isloadEnable=0.
REQ-040 Misaligned word load at addr=0x4002 -> bus_req_valid never asserts, misalign_err=1, and out_valid is asserted 1 cycle after acceptance.
REQ-041 Backpressure: bus_req_ready=0 for 3 cycles and out_ready=0 for 2 cycles -> request fields and outputs stay stable, and in_ready stays 0 throughout.
REQ-042 Reset asserted in WAIT, then bus_rsp_valid pulsed after release -> state=IDLE, out_valid stays 0.

Source files
------------

// File: rtl/lsu_mem.sv
// lsu_mem: single-op load/store unit between execute and writeback.
// Accepts one op at a time and checks its natural alignment.
// Aligned memory ops issue one 64-bit bus request; misaligned and
// non-memory ops skip the bus. Results are held until writeback takes them.
module lsu_mem #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [1:0]      mem_size,
  input  logic            mem_unsigned,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] exc_data_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] exc_data_out,
  output logic [XLEN-1:0] mem_data_out,
  output logic            isloadEnable,
  output logic            misalign_err,
  output logic            bus_req_valid,
  input  logic            bus_req_ready,
  output logic [63:0]     bus_req_addr,
  output logic            bus_req_write,
  output logic [63:0]     bus_req_wdata,
  output logic [7:0]      bus_req_wstrb,
  input  logic            bus_rsp_valid,
  input  logic [63:0]     bus_rsp_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              is_load_q, is_load_d;
  logic              is_store_q, is_store_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   exc_q, exc_d;
  logic [XLEN-1:0]   mem_data_q, mem_data_d;
  logic              isload_q, isload_d;
  logic              misalign_q, misalign_d;

  logic [63:0]       addr64;
  logic [63:0]       wdata64;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  endfunction

  // Byte-enable pattern for the access size, shifted to the byte lane.
  function automatic logic [7:0] size_strb(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    size_strb = base << off;
  endfunction

  // Sign- or zero-extend the low bytes of a right-aligned load value.
  function automatic logic [63:0] load_extend(input logic [63:0] raw,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    b = raw[7:0];
    h = raw[15:0];
    w = raw[31:0];
    case (size)
      2'd0:    load_extend = uns ? {56'd0, raw[7:0]}  : 64'(b);
      2'd1:    load_extend = uns ? {48'd0, raw[15:0]} : 64'(h);
      2'd2:    load_extend = uns ? {32'd0, raw[31:0]} : 64'(w);
      default: load_extend = raw;
    endcase
  endfunction

  assign addr64  = 64'(addr_q);
  assign wdata64 = 64'(wdata_q);

  // Next-state and captured-field logic for the single-op FSM.
  always_comb begin
    state_d    = state_q;
    is_load_d  = is_load_q;
    is_store_d = is_store_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    exc_d      = exc_q;
    mem_data_d = mem_data_q;
    isload_d   = isload_q;
    misalign_d = misalign_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          is_load_d  = is_load;
          is_store_d = is_store;
          size_d     = mem_size;
          uns_d      = mem_unsigned;
          addr_d     = addr;
          wdata_d    = wdata;
          exc_d      = exc_data_in;
          mem_data_d = '0;
          isload_d   = 1'b0;
          misalign_d = (is_load | is_store) &&
                       ((addr[2:0] & align_mask(mem_size)) != 3'b000);
          if ((is_load | is_store) && !misalign_d) state_d = REQ;
          else                                      state_d = DONE;
        end
      end
      REQ: begin
        if (bus_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (bus_rsp_valid) begin
          if (is_load_q) begin
            mem_data_d = XLEN'(load_extend(bus_rsp_rdata >> {addr64[2:0], 3'b000},
                                           size_q, uns_q));
            isload_d   = 1'b1;
          end else begin
            mem_data_d = '0;
            isload_d   = 1'b0;
          end
          state_d = DONE;
        end
      end
      default: begin
        if (out_ready) state_d = IDLE;
      end
    endcase
  end

  // State and captured fields; reset clears everything so outputs read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      exc_q      <= '0;
      mem_data_q <= '0;
      isload_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_load_q  <= is_load_d;
      is_store_q <= is_store_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      exc_q      <= exc_d;
      mem_data_q <= mem_data_d;
      isload_q   <= isload_d;
      misalign_q <= misalign_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign exc_data_out  = exc_q;
  assign mem_data_out  = mem_data_q;
  assign isloadEnable  = isload_q;
  assign misalign_err  = misalign_q;

  assign bus_req_valid = (state_q == REQ);
  assign bus_req_addr  = {addr64[63:3], 3'b000};
  assign bus_req_write = is_store_q;
  assign bus_req_wdata = wdata64 << {addr64[2:0], 3'b000};
  assign bus_req_wstrb = is_store_q ? size_strb(size_q, addr64[2:0]) : 8'h00;

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench for lsu_mem: loads, stores, misalignment, pass-through,
// backpressure, early response and reset during a transaction.
module tb_lsu_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic        is_load, is_store;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [63:0] addr, wdata, exc_data_in;
  logic        out_valid, out_ready;
  logic [63:0] exc_data_out, mem_data_out;
  logic        isloadEnable, misalign_err;
  logic        bus_req_valid, bus_req_ready, bus_req_write;
  logic [63:0] bus_req_addr, bus_req_wdata;
  logic [7:0]  bus_req_wstrb;
  logic        bus_rsp_valid;
  logic [63:0] bus_rsp_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_mem #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .is_load(is_load), .is_store(is_store),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .addr(addr), .wdata(wdata), .exc_data_in(exc_data_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .exc_data_out(exc_data_out), .mem_data_out(mem_data_out),
    .isloadEnable(isloadEnable), .misalign_err(misalign_err),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_addr(bus_req_addr), .bus_req_write(bus_req_write),
    .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; presents an op for one edge.
  task automatic start_op(input logic ld, input logic st, input logic [1:0] sz,
                          input logic uns, input logic [63:0] a,
                          input logic [63:0] wd, input logic [63:0] ex);
    in_valid = 1'b1; is_load = ld; is_store = st; mem_size = sz;
    mem_unsigned = uns; addr = a; wdata = wd; exc_data_in = ex;
    @(posedge clk); #1;
    in_valid = 1'b0; addr = '0; wdata = '0; exc_data_in = '0;
  endtask

  // From REQ: grant immediately, then respond one cycle later; ends in DONE.
  task automatic bus_cycle(input logic [63:0] rd);
    bus_req_ready = 1'b1;
    @(posedge clk); #1;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b1; bus_rsp_rdata = rd;
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ovld_after"}, 64'(out_valid), 64'd0);
    chk({tag, "_inrdy_after"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    mem_size = 2'd0; mem_unsigned = 1'b0; addr = '0; wdata = '0;
    exc_data_in = '0; out_ready = 1'b0; bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;

    // Reset state
    #2;
    chk("rst_ovld", 64'(out_valid), 64'd0);
    chk("rst_breq", 64'(bus_req_valid), 64'd0);
    chk("rst_mis", 64'(misalign_err), 64'd0);
    chk("rst_ldEn", 64'(isloadEnable), 64'd0);
    chk("rst_mdata", mem_data_out, 64'd0);
    chk("rst_exc", exc_data_out, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    chk("rst_inrdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Signed byte load
    start_op(1'b1, 1'b0, 2'd0, 1'b0, 64'h1003, 64'd0, 64'hAAAA);
    chk("lb_breq", 64'(bus_req_valid), 64'd1);
    chk("lb_baddr", bus_req_addr, 64'h1000);
    chk("lb_wstrb", 64'(bus_req_wstrb), 64'h0);
    chk("lb_write", 64'(bus_req_write), 64'd0);
    chk("lb_inrdy", 64'(in_ready), 64'd0);
    bus_cycle(64'h00000000_80000000);
    chk("lb_ovld", 64'(out_valid), 64'd1);
    chk("lb_mdata", mem_data_out, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_ldEn", 64'(isloadEnable), 64'd1);
    chk("lb_mis", 64'(misalign_err), 64'd0);
    chk("lb_exc", exc_data_out, 64'hAAAA);
    finish_op("lb");

    // Unsigned word load
    start_op(1'b1, 1'b0, 2'd2, 1'b1, 64'h2004, 64'd0, 64'h55);
    chk("lwu_baddr", bus_req_addr, 64'h2000);
    bus_cycle(64'hDEADBEEF_00000000);
    chk("lwu_mdata", mem_data_out, 64'h0000_0000_DEAD_BEEF);
    chk("lwu_ldEn", 64'(isloadEnable), 64'd1);
    finish_op("lwu");

    // Signed half load
    start_op(1'b1, 1'b0, 2'd1, 1'b0, 64'h7002, 64'd0, 64'd0);
    bus_cycle(64'h00000000_80010000);
    chk("lh_mdata", mem_data_out, 64'hFFFF_FFFF_FFFF_8001);
    finish_op("lh");

    // Store half
    start_op(1'b0, 1'b1, 2'd1, 1'b0, 64'h3006, 64'h1234, 64'h77);
    chk("sh_baddr", bus_req_addr, 64'h3000);
    chk("sh_wstrb", 64'(bus_req_wstrb), 64'hC0);
    chk("sh_wdata", bus_req_wdata, 64'h1234_0000_0000_0000);
    chk("sh_write", 64'(bus_req_write), 64'd1);
    bus_cycle(64'hFFFF_FFFF_FFFF_FFFF);
    chk("sh_ovld", 64'(out_valid), 64'd1);
    chk("sh_ldEn", 64'(isloadEnable), 64'd0);
    chk("sh_mdata", mem_data_out, 64'd0);
    chk("sh_exc", exc_data_out, 64'h77);
    finish_op("sh");

    // Misaligned word load: straight to DONE, no bus request
    start_op(1'b1, 1'b0, 2'd2, 1'b0, 64'h4002, 64'd0, 64'h99);
    chk("mis_ovld", 64'(out_valid), 64'd1);
    chk("mis_breq", 64'(bus_req_valid), 64'd0);
    chk("mis_err", 64'(misalign_err), 64'd1);
    chk("mis_ldEn", 64'(isloadEnable), 64'd0);
    chk("mis_mdata", mem_data_out, 64'd0);
    finish_op("mis");

    // Non-memory op: pass-through, latency 1
    start_op(1'b0, 1'b0, 2'd3, 1'b0, 64'h4001, 64'd0, 64'hCAFE_F00D);
    chk("alu_ovld", 64'(out_valid), 64'd1);
    chk("alu_breq", 64'(bus_req_valid), 64'd0);
    chk("alu_mis", 64'(misalign_err), 64'd0);
    chk("alu_exc", exc_data_out, 64'hCAFE_F00D);
    chk("alu_mdata", mem_data_out, 64'd0);
    finish_op("alu");

    // Backpressure on both bus request and writeback
    start_op(1'b0, 1'b1, 2'd3, 1'b0, 64'h6000, 64'h0123_4567_89AB_CDEF, 64'h1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_breq", 64'(bus_req_valid), 64'd1);
      chk("bp_wdata", bus_req_wdata, 64'h0123_4567_89AB_CDEF);
      chk("bp_wstrb", 64'(bus_req_wstrb), 64'hFF);
      chk("bp_baddr", bus_req_addr, 64'h6000);
      chk("bp_inrdy", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    bus_cycle(64'd0);
    for (int i = 0; i < 2; i++) begin
      chk("bp_ovld", 64'(out_valid), 64'd1);
      chk("bp_exc", exc_data_out, 64'h1);
      chk("bp_inrdy2", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    finish_op("bp");

    // Response coinciding with the grant must be ignored
    start_op(1'b1, 1'b0, 2'd3, 1'b0, 64'h5000, 64'd0, 64'd0);
    bus_req_ready = 1'b1; bus_rsp_valid = 1'b1; bus_rsp_rdata = 64'h1111;
    @(posedge clk); #1;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;
    @(posedge clk); #1;
    chk("early_ovld", 64'(out_valid), 64'd0);
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 64'h8877_6655_4433_2211;
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0;
    chk("early_ovld2", 64'(out_valid), 64'd1);
    chk("early_mdata", mem_data_out, 64'h8877_6655_4433_2211);
    finish_op("early");

    // Reset in WAIT, stray response afterwards
    start_op(1'b1, 1'b0, 2'd0, 1'b0, 64'h8000, 64'd0, 64'h42);
    bus_req_ready = 1'b1;
    @(posedge clk); #1;
    bus_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rw_inrdy", 64'(in_ready), 64'd1);
    chk("rw_exc", exc_data_out, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 64'hFF;
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0;
    chk("rw_ovld", 64'(out_valid), 64'd0);
    chk("rw_inrdy2", 64'(in_ready), 64'd1);
    chk("rw_ldEn", 64'(isloadEnable), 64'd0);

    // Asynchronous reset while holding a result in DONE
    start_op(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 64'h1234);
    chk("ar_ovld_pre", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #2;
    chk("ar_ovld", 64'(out_valid), 64'd0);
    chk("ar_exc", exc_data_out, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
